// File: rtl/button_gesture_pkg.sv
// button_gesture_pkg
//   Shared types and helpers for the button gesture classifier.
//   - state_t     : gesture FSM state encoding (3 bits)
//   - timer_width : width of the gesture timer, large enough to hold the
//                   largest of the three cycle parameters
package button_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP  = 3'd2,
    WREL = 3'd3,
    LONG = 3'd4
  } state_t;

  function automatic int timer_width(input int long_cycles,
                                     input int dclick_cycles,
                                     input int repeat_cycles);
    int m;
    m = long_cycles;
    if (dclick_cycles > m) m = dclick_cycles;
    if (repeat_cycles > m) m = repeat_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_gesture_timer.sv
// gesture_timer
//   Up-counter used by the gesture FSM to measure hold and gap durations.
//   Synchronous clear wins over enable; the count saturates at all-ones so
//   a long idle or hold never wraps back into a compare window.
// Ports:
//   clk   : system clock
//   rst   : asynchronous, active-low reset (count -> 0)
//   clr   : synchronous clear
//   en    : count enable
//   count : current count
module gesture_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/button_gesture.sv
// button_gesture
//   Classifies a debounced button level into one-cycle event pulses:
//   single click, double click or long press. All timing is in clk cycles.
//   Optional build macro BUTTON_GESTURE_REPEAT_EN: while the button stays
//   held after a long press, long_press re-pulses every REPEAT_CYCLES.
// Ports:
//   clk          : system clock
//   rst          : asynchronous, active-low reset
//   btn_db       : debounced button level (1 = pressed), synchronous to clk
//   single_click : one-cycle pulse, single click recognised
//   double_click : one-cycle pulse, double click recognised
//   long_press   : one-cycle pulse, long-press threshold (or repeat) reached
//   busy         : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | no gesture in progress
// P1    | first press held, timing toward long press
// GAP   | released after first press, waiting for a second press
// WREL  | double click reported, waiting for release
// LONG  | long press reported, waiting for release (repeats if enabled)
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int LONG_CYCLES   = 12000000,
  parameter int DCLICK_CYCLES = 3600000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_db,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  localparam int TW = timer_width(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`endif

  if ((LONG_CYCLES < 2) || (DCLICK_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_bad_param
    $error("button_gesture: cycle parameters must be >= 2");
  end

  state_t          state_q;
  state_t          state_d;
  logic            btn_q;
  logic            rise;
  logic            fall;
  logic [TW-1:0]   count;
  logic            timer_clr;
  logic            rep_clr;
  logic            single_d;
  logic            double_d;
  logic            long_d;

  // btn_q resets high so a button held through reset looks already pressed
  // and cannot produce a rise until it has been released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_db;
    end
  end

  assign rise = btn_db & ~btn_q;
  assign fall = ~btn_db & btn_q;

  assign timer_clr = (state_d != state_q) | rep_clr;

  gesture_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (1'b1),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      state_q      <= state_d;
      single_click <= single_d;
      double_click <= double_d;
      long_press   <= long_d;
    end
  end

  // Edges are tested before timer expiry in every state so a button edge
  // landing on the expiry cycle always wins.
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = P1;
      end
      P1: begin
        if (fall) begin
          state_d = GAP;
        end else if (count == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d  = WREL;
          double_d = 1'b1;
        end else if (count == DCLICK_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      WREL: begin
        if (fall) state_d = IDLE;
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
        end
`ifdef BUTTON_GESTURE_REPEAT_EN
        else if (count == REPEAT_LAST) begin
          long_d  = 1'b1;
          rep_clr = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_button_gesture.sv
module tb_button_gesture;

  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_db;
  logic single_click;
  logic double_click;
  logic long_press;
  logic busy;

  int errors = 0;
  int checks = 0;

  button_gesture #(
    .LONG_CYCLES   (L),
    .DCLICK_CYCLES (D),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_db       (btn_db),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks gesture phases by the edge index at which they
  // began and decides events from elapsed-cycle arithmetic.
  int  t;
  int  press_at;
  int  gap_at;
  int  long_at;
  bit  dbl_hold;
  bit  prev;
  bit  m_s, m_d, m_l, m_busy;

  task automatic model_reset();
    t = 0; press_at = -1; gap_at = -1; long_at = -1;
    dbl_hold = 1'b0; prev = 1'b1;
    m_s = 1'b0; m_d = 1'b0; m_l = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_edge(input bit b);
    bit r, f;
    r = b & ~prev;
    f = ~b & prev;
    prev = b;
    t++;
    m_s = 1'b0; m_d = 1'b0; m_l = 1'b0;
    if (press_at >= 0) begin
      if (f) begin
        press_at = -1; gap_at = t;
      end else if (t - press_at == L) begin
        m_l = 1'b1; press_at = -1; long_at = t;
      end
    end else if (gap_at >= 0) begin
      if (r) begin
        m_d = 1'b1; gap_at = -1; dbl_hold = 1'b1;
      end else if (t - gap_at == D) begin
        m_s = 1'b1; gap_at = -1;
      end
    end else if (dbl_hold) begin
      if (f) dbl_hold = 1'b0;
    end else if (long_at >= 0) begin
      if (f) long_at = -1;
`ifdef BUTTON_GESTURE_REPEAT_EN
      else if (t - long_at == R) begin
        m_l = 1'b1; long_at = t;
      end
`endif
    end else if (r) begin
      press_at = t;
    end
    m_busy = (press_at >= 0) || (gap_at >= 0) || dbl_hold || (long_at >= 0);
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got{s,d,l,busy}=%b exp=%b", name, t, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int cnt_s, cnt_d, cnt_l;

  // One clock: drive level, let the edge happen, compare against the model
  // on the falling edge.
  task automatic step(input bit b);
    btn_db = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    cnt_s += int'(single_click);
    cnt_d += int'(double_click);
    cnt_l += int'(long_press);
    check4("cycle", {single_click, double_click, long_press, busy},
           {m_s, m_d, m_l, m_busy});
  endtask

  task automatic clear_counts();
    cnt_s = 0; cnt_d = 0; cnt_l = 0;
  endtask

  // Asserted just after a falling edge; outputs must drop without a clock.
  task automatic reset_pulse(input bit hold_level, input string name);
    btn_db = hold_level;
    rst = 1'b0;
    model_reset();
    #1;
    check4(name, {single_click, double_click, long_press, busy}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit    level;
    int    cycles;
    int    exp_s;
    int    exp_d;
    int    exp_l;
    string name;
  } seg_t;

  seg_t tbl[$];

  initial begin
    int first;
    int long_rows;
`ifdef BUTTON_GESTURE_REPEAT_EN
    long_rows = 4;
`else
    long_rows = 1;
`endif
    tbl.push_back('{1'b0, 15, 0, 0, 0, "idle_low"});
    tbl.push_back('{1'b1,  5, 0, 0, 0, "sc_press"});
    tbl.push_back('{1'b0, 15, 1, 0, 0, "sc_release"});
    tbl.push_back('{1'b1,  5, 0, 0, 0, "dc_press1"});
    tbl.push_back('{1'b0,  4, 0, 0, 0, "dc_gap"});
    tbl.push_back('{1'b1,  3, 0, 1, 0, "dc_press2"});
    tbl.push_back('{1'b0, 15, 0, 0, 0, "dc_release"});
    tbl.push_back('{1'b1, 40, 0, 0, long_rows, "long_hold"});
    tbl.push_back('{1'b0, 15, 0, 0, 0, "long_release"});
    tbl.push_back('{1'b1, 20, 0, 0, 0, "race_p1_hold"});
    tbl.push_back('{1'b0, 15, 1, 0, 0, "race_p1_release"});
    tbl.push_back('{1'b1,  5, 0, 0, 0, "race_gap_press"});
    tbl.push_back('{1'b0, 10, 0, 0, 0, "race_gap_wait"});
    tbl.push_back('{1'b1,  3, 0, 1, 0, "race_gap_rise"});
    tbl.push_back('{1'b0, 15, 0, 0, 0, "race_gap_release"});
    tbl.push_back('{1'b1,  3, 0, 0, 0, "b2b_click1"});
    tbl.push_back('{1'b0,  4, 0, 0, 0, "b2b_gap1"});
    tbl.push_back('{1'b1,  3, 0, 1, 0, "b2b_click2"});
    tbl.push_back('{1'b0,  4, 0, 0, 0, "b2b_gap2"});
    tbl.push_back('{1'b1,  3, 0, 0, 0, "b2b_click3"});
    tbl.push_back('{1'b0, 15, 1, 0, 0, "b2b_tail"});

    // Power-on reset with button released.
    rst = 1'b0;
    btn_db = 1'b0;
    model_reset();
    clear_counts();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check4("reset_state", {single_click, double_click, long_press, busy}, 4'b0000);
    rst = 1'b1;

    // Directed segments with hand-derived pulse counts.
    foreach (tbl[i]) begin
      clear_counts();
      for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].level);
      check_int({tbl[i].name, "_single"}, cnt_s, tbl[i].exp_s);
      check_int({tbl[i].name, "_double"}, cnt_d, tbl[i].exp_d);
      check_int({tbl[i].name, "_long"},   cnt_l, tbl[i].exp_l);
    end
    check_int("idle_after_table", int'(busy), 0);

    // Exact single-click latency: pulse on the 11th low sample.
    for (int k = 0; k < 5; k++) step(1'b1);
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step(1'b0);
      if (single_click && first == 0) first = k;
    end
    check_int("single_latency", first, D + 1);

    // Exact long-press latency: pulse on the 21st high sample.
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1'b1);
      if (long_press && first == 0) first = k;
    end
    check_int("long_latency", first, L + 1);
    for (int k = 0; k < 5; k++) step(1'b0);

    // Button held through reset: silent until a release and fresh press.
    reset_pulse(1'b1, "rst_held_drop");
    clear_counts();
    for (int k = 0; k < 30; k++) step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    check_int("held_through_reset_events", cnt_s + cnt_d + cnt_l, 0);
    clear_counts();
    for (int k = 0; k < 3; k++) step(1'b1);
    for (int k = 0; k < 15; k++) step(1'b0);
    check_int("fresh_press_single", cnt_s, 1);

    // Reset mid-GAP aborts silently.
    for (int k = 0; k < 5; k++) step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);
    check_int("busy_in_gap", int'(busy), 1);
    reset_pulse(1'b0, "rst_mid_gap");
    clear_counts();
    for (int k = 0; k < 15; k++) step(1'b0);
    check_int("no_single_after_rst", cnt_s, 0);

    // Reset while a pulse is high drops it immediately.
    for (int k = 0; k < 5; k++) step(1'b1);
    first = 0;
    for (int k = 0; k < 20 && first == 0; k++) begin
      step(1'b0);
      if (single_click) first = 1;
    end
    check_int("pulse_seen_before_rst", first, 1);
    reset_pulse(1'b0, "rst_drops_pulse");

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 220; seg++) begin
      int len;
      int pick;
      bit lvl;
      pick = int'($urandom_range(0, 3));
      case (pick)
        0: len = int'($urandom_range(1, 6));
        1: len = int'($urandom_range(D - 2, D + 2));
        2: len = int'($urandom_range(L - 2, L + 2));
        default: len = int'($urandom_range(25, 45));
      endcase
      lvl = seg[0];
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse(1'(($urandom_range(0, 1))), "rst_random");
      end
      for (int k = 0; k < len; k++) step(lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
